// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// One shift-and-add unsigned multiplier shared by two requesters under a
// round-robin arbiter. A product takes N RUN cycles plus one DONE cycle.
// The following IDLE cycle is the only place where a new request can be
// accepted, so back-to-back throughput is one product every N+2 cycles.
//
// Ports
//   clk              : single clock, all state updates on the rising edge
//   reset            : synchronous, active-high; clears everything, including
//                      a transaction in flight (no done pulse is produced)
//   req0 / req1      : level-sensitive multiply requests
//   b_in0 / q_in0    : multiplicand / multiplier of requester 0 (N bits)
//   b_in1 / q_in1    : multiplicand / multiplier of requester 1 (N bits)
//   gnt0 / gnt1      : registered one-cycle acceptance pulses
//   done0 / done1    : registered one-cycle result-valid pulses
//   busy             : high while the FSM is in RUN or DONE
//   a_out            : 2N-bit product accumulator; holds the last product
//                      until the next capture clears it
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [N-1:0]   b_in0,
  input  logic [N-1:0]   q_in0,
  input  logic [N-1:0]   b_in1,
  input  logic [N-1:0]   q_in1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic           busy,
  output logic [2*N-1:0] a_out
);

  // Counter must be able to hold the value N reached after the last RUN step.
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Round-robin pick. Returns 1 when requester 1 wins. A sole requester
  // always wins; on a tie the requester not served last wins.
  function automatic logic pick_winner(input logic rq0, input logic rq1,
                                       input logic last_served);
    if (rq0 && rq1) begin
      return ~last_served;
    end
    return rq1;
  endfunction

  logic [1:0]     r_state;
  logic [2*N-1:0] r_b;
  logic [N-1:0]   r_q;
  logic [2*N-1:0] r_a;
  logic [CW-1:0]  r_cnt;
  logic           r_last;   // requester captured most recently
  logic           r_owner;  // requester of the transaction in flight
  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_done0;
  logic           r_done1;

  logic           w_any_req;
  logic           w_pick;
  logic [N-1:0]   w_b_sel;
  logic [N-1:0]   w_q_sel;
  logic           w_last_run;

  assign w_any_req  = req0 | req1;
  assign w_pick     = pick_winner(req0, req1, r_last);
  assign w_b_sel    = w_pick ? b_in1 : b_in0;
  assign w_q_sel    = w_pick ? q_in1 : q_in0;
  assign w_last_run = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_q     <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b1;   // so requester 0 wins the first tie
      r_owner <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      // Pulses default low; they are only raised for a single cycle.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Operands are sampled here only; later input changes are ignored.
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_b     <= {{N{1'b0}}, w_b_sel};
            r_q     <= w_q_sel;
            r_a     <= '0;
            r_cnt   <= '0;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Fixed N steps, no early exit, so latency never depends on data.
          if (r_q[0]) begin
            r_a <= r_a + r_b;
          end
          r_b   <= r_b << 1;
          r_q   <= r_q >> 1;
          r_cnt <= r_cnt + CNT_ONE;
          if (w_last_run) begin
            r_state <= S_DONE;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
          end
        end

        S_DONE: begin
          // No arbitration here; pending requests are seen in the next IDLE.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign busy  = (r_state != S_IDLE);
  assign a_out = r_a;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
//
// Directed bench for mul_share_arbiter (N = 8). Inputs change 1 ns after a
// rising edge and outputs are observed at the same point, so each step()
// moves the bench into the next clock cycle.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int N = 8;

  logic           clk;
  logic           reset;
  logic           req0;
  logic           req1;
  logic [N-1:0]   b_in0;
  logic [N-1:0]   q_in0;
  logic [N-1:0]   b_in1;
  logic [N-1:0]   q_in1;
  logic           gnt0;
  logic           gnt1;
  logic           done0;
  logic           done1;
  logic           busy;
  logic [2*N-1:0] a_out;

  int checks;
  int failures;

  mul_share_arbiter #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .b_in0 (b_in0),
    .q_in0 (q_in0),
    .b_in1 (b_in1),
    .q_in1 (q_in1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .a_out (a_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the exclusivity rules that hold in every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_exclusive",  {31'd0, gnt0 & gnt1}, 32'd0);
    chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
    chk("gnt_and_done",   {31'd0, (gnt0 | gnt1) & (done0 | done1)}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    b_in0    = '0;
    q_in0    = '0;
    b_in1    = '0;
    q_in1    = '0;

    // Reset state
    step();
    step();
    chk("rst_gnt0",  gnt0,  0);
    chk("rst_gnt1",  gnt1,  0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_a_out", a_out, 0);
    reset = 1'b0;

    // Single request 13 x 11
    req0 = 1'b1; b_in0 = 8'd13; q_in0 = 8'd11;
    step();
    chk("A_gnt0", gnt0, 1);
    chk("A_gnt1", gnt1, 0);
    chk("A_busy_c1", busy, 1);
    req0 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("A_run_busy", busy, 1);
      chk("A_run_done0", done0, 0);
      chk("A_run_gnt0", gnt0, 0);
    end
    step();
    chk("A_done0", done0, 1);
    chk("A_done1", done1, 0);
    chk("A_a_out", a_out, 143);
    chk("A_busy_c9", busy, 1);
    step();
    chk("A_done0_low", done0, 0);
    chk("A_busy_c10", busy, 0);
    chk("A_a_out_hold", a_out, 143);

    // Tie after reset: 255 x 255 to req0 first, then 3 x 5 to req1
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("B_rst_busy", busy, 0);
    chk("B_rst_a_out", a_out, 0);
    req0 = 1'b1; req1 = 1'b1;
    b_in0 = 8'd255; q_in0 = 8'd255; b_in1 = 8'd3; q_in1 = 8'd5;
    step();
    chk("B_gnt0", gnt0, 1);
    chk("B_gnt1_first", gnt1, 0);
    req0 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("B_wait_gnt1", gnt1, 0);
    end
    step();
    chk("B_done0", done0, 1);
    chk("B_a_out0", a_out, 65025);
    chk("B_gnt1_in_done", gnt1, 0);
    step();
    chk("B_idle_busy", busy, 0);
    chk("B_idle_gnt1", gnt1, 0);
    step();
    chk("B_gnt1", gnt1, 1);
    chk("B_busy_run1", busy, 1);
    req1 = 1'b0;
    for (int k = 12; k <= 18; k++) begin
      step();
      chk("B_run1_done1", done1, 0);
    end
    step();
    chk("B_done1", done1, 1);
    chk("B_done0_low", done0, 0);
    chk("B_a_out1", a_out, 15);
    step();
    chk("B_end_busy", busy, 0);

    // Both requests held for four transactions: grants alternate 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    b_in0 = 8'd2; q_in0 = 8'd3; b_in1 = 8'd4; q_in1 = 8'd5;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("C_gnt0", gnt0, (t % 2 == 0) ? 1 : 0);
      chk("C_gnt1", gnt1, (t % 2 == 1) ? 1 : 0);
      for (int k = 2; k <= 8; k++) begin
        step();
        chk("C_run_done", {31'd0, done0 | done1}, 0);
      end
      step();
      chk("C_done0", done0, (t % 2 == 0) ? 1 : 0);
      chk("C_done1", done1, (t % 2 == 1) ? 1 : 0);
      chk("C_a_out", a_out, (t % 2 == 0) ? 6 : 20);
      step();
      chk("C_idle_busy", busy, 0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Zero multiplier, then zero multiplicand
    req1 = 1'b1; b_in1 = 8'd200; q_in1 = 8'd0;
    step();
    chk("D_gnt1", gnt1, 1);
    req1 = 1'b0;
    for (int k = 2; k <= 8; k++) step();
    step();
    chk("D_done1_q0", done1, 1);
    chk("D_a_out_q0", a_out, 0);
    step();
    req1 = 1'b1; b_in1 = 8'd0; q_in1 = 8'd255;
    step();
    chk("D_gnt1_b0", gnt1, 1);
    req1 = 1'b0;
    for (int k = 2; k <= 8; k++) step();
    step();
    chk("D_done1_b0", done1, 1);
    chk("D_a_out_b0", a_out, 0);
    step();

    // Reset in the 4th RUN cycle of 7 x 9, then a tie goes to req0
    req0 = 1'b1; b_in0 = 8'd7; q_in0 = 8'd9;
    step();
    chk("E_gnt0", gnt0, 1);
    req0 = 1'b0;
    step();
    step();
    step();
    chk("E_partial_a_out", a_out, 7);
    chk("E_busy_pre", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("E_rst_busy", busy, 0);
    chk("E_rst_a_out", a_out, 0);
    chk("E_rst_done0", done0, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("E_no_done0", done0, 0);
      chk("E_idle_busy", busy, 0);
    end
    req0 = 1'b1; req1 = 1'b1;
    b_in1 = 8'd10; q_in1 = 8'd10;
    step();
    chk("E_tie_gnt0", gnt0, 1);
    chk("E_tie_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 2; k <= 8; k++) step();
    step();
    chk("E_done0", done0, 1);
    chk("E_a_out", a_out, 63);
    step();

    // req1 raised and operands changed while req0 runs
    req0 = 1'b1; b_in0 = 8'd12; q_in0 = 8'd10;
    step();
    chk("F_gnt0", gnt0, 1);
    req0 = 1'b0;
    req1 = 1'b1; b_in1 = 8'd6; q_in1 = 8'd7;
    b_in0 = 8'd255; q_in0 = 8'd255;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("F_run_gnt1", gnt1, 0);
    end
    step();
    chk("F_done0", done0, 1);
    chk("F_a_out0", a_out, 120);
    chk("F_gnt1_in_done", gnt1, 0);
    step();
    chk("F_idle_gnt1", gnt1, 0);
    chk("F_idle_busy", busy, 0);
    step();
    chk("F_gnt1", gnt1, 1);
    req1 = 1'b0;
    for (int k = 12; k <= 18; k++) step();
    step();
    chk("F_done1", done1, 1);
    chk("F_a_out1", a_out, 42);
    step();
    chk("F_end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each, level-sensitive multiply requests from requester 0 and requester 1.
REQ-005 The block SHALL have ports b_in0, q_in0, b_in1 and q_in1, input, N each, giving the multiplicand and multiplier of each requester.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 each, registered, one-cycle acceptance pulses.
REQ-007 The block SHALL have ports done0 and done1, output, 1 each, registered, one-cycle result-valid pulses.
REQ-008 The block SHALL have port busy, output, 1, high while in state RUN or state DONE.
REQ-009 The block SHALL have port a_out, output, 2N, the product accumulator.

Function
REQ-010 The block SHALL use an FSM with three states: IDLE, RUN and DONE.
REQ-011 In IDLE with at least one request active, the winner SHALL be captured at the clock edge, and the block SHALL enter RUN with:
- B <= {N'b0, b_inX} (2N-bit register);
- Q <= q_inX;
- A (a_out) <= 0;
- count <= 0;
- gntX <= 1.
REQ-012 Arbitration SHALL be round-robin:
- a sole requester always wins;
- on a tie, the requester not served last wins;
- the "last served" pointer updates at capture.
REQ-013 Each RUN cycle SHALL perform:
- if Q[0] is set, A <= A + B;
- B <= B << 1;
- Q <= Q >> 1;
- count <= count + 1.
REQ-014 RUN SHALL last exactly N cycles regardless of operand values, with no early exit on zero.
REQ-015 After the Nth RUN cycle, the block SHALL enter DONE, and doneX (X = captured requester) SHALL be high for exactly the DONE cycle.
REQ-016 DONE SHALL always go to IDLE; no arbitration occurs in DONE.
REQ-017 Latency: with the request sampled in cycle c0:
- gntX is high in cycle c0+1 only;
- doneX is high in cycle c0+N+1;
- back-to-back throughput is one product per N+2 cycles.
REQ-018 a_out SHALL equal b_inX*q_inX (unsigned) during DONE, and SHALL hold that value until the next capture clears it.
REQ-019 Accumulator and B SHALL be 2N bits wide; no overflow is possible, since (2^N-1)^2 < 2^2N.
REQ-020 Operands SHALL be sampled only at the capture edge; later changes on b_in/q_in SHALL NOT affect the result.
REQ-021 Requests arriving during RUN or DONE SHALL NOT be granted; they wait, and are arbitrated in the next IDLE cycle.
REQ-022 A requester still asserting req in the IDLE cycle after its done SHALL be treated as a new request.
REQ-023 At most one of gnt0/gnt1 SHALL be high in any cycle, and likewise at most one of done0/done1.
REQ-024 gnt and done SHALL never be high in the same cycle.

Reset
REQ-025 With reset high at a rising edge, the block SHALL enter IDLE and drive:
- gnt0 = gnt1 = 0;
- done0 = done1 = 0;
- busy = 0;
- a_out = 0;
- B = 0, Q = 0, count = 0;
- last-served pointer = requester 1, so req0 wins the first tie.
REQ-026 Reset SHALL take priority over all other activity, including mid-RUN and in DONE.
REQ-027 A transaction interrupted by reset SHALL be discarded, with no done pulse.
REQ-028 Outputs SHALL be stable from the first cycle after the reset edge; there is no reset-release latency beyond one clock.

Verification (N=8)
REQ-029 After reset, drive req0=1, b_in0=13, q_in0=11 in cycle c0 -> gnt0 high in c0+1, done0 high in c0+9, a_out=143, busy high c0+1..c0+9.
REQ-030 After reset, drive req0 and req1 together (255x255, 3x5) and drop each req after its gnt -> done0 with a_out=65025 first, then gnt1 in the cycle after done0's IDLE, and done1 with a_out=15 exactly 10 cycles after done0.
REQ-031 Hold req0 and req1 high continuously for 4 transactions -> grants alternate 0,1,0,1 and done pulses are spaced 10 cycles apart.
REQ-032 Drive req1=1 with q_in1=0 and b_in1=200 -> done1 still arrives at c0+9 with a_out=0; repeating with b_in1=0 and q_in1=255 also gives a_out=0.
REQ-033 Start req0 (7x9), assert reset in the 4th RUN cycle, then tie-request -> no done0, a_out=0 and busy=0 after the reset edge; the subsequent tie is granted to req0, giving 63.
REQ-034 Raise req1 during req0's RUN and change b_in0 mid-RUN -> req0's result is unaffected, and gnt1 arrives only after done0 plus one IDLE cycle.
